axi_lite_reg_responder: RTL and testbench

//  AXI4-Lite slave (responder) holding NUM_REGS 32-bit control registers for the custom AXI-lite IP.

---
 rtl/axi_lite_reg_responder.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_reg_responder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_responder.sv
// axi_lite_reg_responder: AXI4-Lite slave holding NUM_REGS 32-bit control registers.
// Ports: ACLK/ARESET, S_AXI_AW*/W*/B* (write), S_AXI_AR*/R* (read), reg_out, wr_pulse.
module axi_lite_reg_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int NUM_REGS           = 4
) (
   input  logic                             ACLK,
   input  logic                             ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
   input  logic [2:0]                       S_AXI_AWPROT,
   input  logic                             S_AXI_AWVALID,
   output logic                             S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
   input  logic                             S_AXI_WVALID,
   output logic                             S_AXI_WREADY,
   output logic [1:0]                       S_AXI_BRESP,
   output logic                             S_AXI_BVALID,
   input  logic                             S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
   input  logic [2:0]                       S_AXI_ARPROT,
   input  logic                             S_AXI_ARVALID,
   output logic                             S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
   output logic [1:0]                       S_AXI_RRESP,
   output logic                             S_AXI_RVALID,
   input  logic                             S_AXI_RREADY,
   output logic [32*NUM_REGS-1:0]           reg_out,
   output logic [NUM_REGS-1:0]              wr_pulse
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int IW = AW - 2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {WR_IDLE, WR_WAIT_W, WR_WAIT_A, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

   wr_state_t              r_wstate;
   rd_state_t              r_rstate;
   logic                   r_awready, r_wready, r_bvalid;
   logic [1:0]             r_bresp;
   logic                   r_arready, r_rvalid;
   logic [1:0]             r_rresp;
   logic [31:0]            r_rdata;
   logic [AW-1:0]          r_awaddr;
   logic [31:0]            r_wdata;
   logic [3:0]             r_wstrb;
   logic [32*NUM_REGS-1:0] r_regs;
   logic [NUM_REGS-1:0]    r_wr_pulse;

   logic                   w_aw_hs, w_w_hs, w_ar_hs;
   logic                   w_wr_fire, w_wr_in, w_rd_in;
   logic [AW-1:0]          w_wr_addr;
   logic [31:0]            w_wr_data, w_rd_data;
   logic [3:0]             w_wr_strb;
   logic [IW-1:0]          w_wr_idx, w_rd_idx;
   logic                   w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign w_aw_hs = S_AXI_AWVALID & r_awready;
   assign w_w_hs  = S_AXI_WVALID & r_wready;
   assign w_ar_hs = S_AXI_ARVALID & r_arready;

   // Merge live channel inputs with whichever half was latched earlier.
   always_comb begin
      w_wr_addr = S_AXI_AWADDR;
      w_wr_data = S_AXI_WDATA;
      w_wr_strb = S_AXI_WSTRB;
      w_wr_fire = 1'b0;
      unique case (r_wstate)
         WR_IDLE:   w_wr_fire = w_aw_hs & w_w_hs;
         WR_WAIT_W: begin
            w_wr_addr = r_awaddr;
            w_wr_fire = w_w_hs;
         end
         WR_WAIT_A: begin
            w_wr_data = r_wdata;
            w_wr_strb = r_wstrb;
            w_wr_fire = w_aw_hs;
         end
         default: ;
      endcase
   end

   assign w_wr_idx = w_wr_addr[AW-1:2];
   assign w_rd_idx = S_AXI_ARADDR[AW-1:2];
   assign w_wr_in  = 32'(w_wr_idx) < NUM_REGS;
   assign w_rd_in  = 32'(w_rd_idx) < NUM_REGS;

   // Out-of-range indices match no register, so they read as zero.
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (32'(w_rd_idx) == i) w_rd_data = r_regs[32*i +: 32];
   end

   // Write channel FSM; READYs come up on the first edge after reset.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_wstate  <= WR_IDLE;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= OKAY;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else if (w_wr_fire) begin
         r_wstate  <= WR_RESP;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b1;
         r_bresp   <= w_wr_in ? OKAY : SLVERR;
      end else begin
         unique case (r_wstate)
            WR_IDLE: begin
               if (w_aw_hs) begin
                  r_awaddr  <= S_AXI_AWADDR;
                  r_awready <= 1'b0;
                  r_wstate  <= WR_WAIT_W;
               end else if (w_w_hs) begin
                  r_wdata  <= S_AXI_WDATA;
                  r_wstrb  <= S_AXI_WSTRB;
                  r_wready <= 1'b0;
                  r_wstate <= WR_WAIT_A;
               end else begin
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            WR_RESP: begin
               if (S_AXI_BREADY) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= WR_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Register file and one-cycle write strobes.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_regs     <= '0;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_fire && w_wr_in && 32'(w_wr_idx) == i) begin
               r_wr_pulse[i] <= 1'b1;
               for (int b = 0; b < 4; b++)
                  if (w_wr_strb[b])
                     r_regs[32*i+8*b +: 8] <= w_wr_data[8*b +: 8];
            end
         end
      end
   end

   // Read channel FSM; data is captured from pre-write register contents.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rstate  <= RD_IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= OKAY;
      end else begin
         unique case (r_rstate)
            RD_IDLE: begin
               if (w_ar_hs) begin
                  r_rdata   <= w_rd_data;
                  r_rresp   <= w_rd_in ? OKAY : SLVERR;
                  r_arready <= 1'b0;
                  r_rvalid  <= 1'b1;
                  r_rstate  <= RD_DATA;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            RD_DATA: begin
               if (S_AXI_RREADY) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= RD_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;
   assign reg_out       = r_regs;
   assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// tb_axi_lite_reg_responder: directed checks of the AXI-lite register responder.
// Drives and samples on the falling clock edge.
module tb_axi_lite_reg_responder;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [4:0]   awaddr = '0;
   logic [2:0]   awprot = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b0;
   logic [4:0]   araddr = '0;
   logic [2:0]   arprot = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b0;
   logic [127:0] reg_out;
   logic [3:0]   wr_pulse;

   int total = 0;
   int bad = 0;
   int pcnt [4] = '{0, 0, 0, 0};

   always #5 clk = ~clk;

   axi_lite_reg_responder dut (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
      .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
      .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   always @(negedge clk)
      for (int i = 0; i < 4; i++)
         if (wr_pulse[i]) pcnt[i]++;

   // Full write transaction; lat = negedges waited for BVALID after both hs (-1 timeout).
   task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp,
                           output int lat);
      bit awd, wd, ha, hw;
      int n;
      @(negedge clk);
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      awd = 0; wd = 0; n = 0;
      while (!(awd && wd) && n < 20) begin
         ha = awvalid & awready;
         hw = wvalid & wready;
         @(negedge clk);
         if (ha) begin awvalid = 1'b0; awd = 1; end
         if (hw) begin wvalid = 1'b0; wd = 1; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      lat = 0;
      while (!bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      resp = bresp;
      if (!bvalid) lat = -1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
      int n;
      @(negedge clk);
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      d = rdata; resp = rresp;
      if (!rvalid) lat = -1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
         bad++;
         $display("FAIL rst_ctl: got %b want 00000",
                  {awready, wready, arready, bvalid, rvalid});
      end
      total++;
      if ({bresp, rresp, rdata, wr_pulse} !== 40'b0) begin
         bad++;
         $display("FAIL rst_data: got %h want 0",
                  {bresp, rresp, rdata, wr_pulse});
      end
      total++;
      if (reg_out !== 128'b0) begin
         bad++;
         $display("FAIL rst_regs: got %h want 0", reg_out);
      end
      rst = 1'b0;
      #1;
      total++;
      if ({awready, wready, arready} !== 3'b000) begin
         bad++;
         $display("FAIL rst_rel_noedge: got %b want 000",
                  {awready, wready, arready});
      end
      @(negedge clk);
      total++;
      if ({awready, wready, arready} !== 3'b111) begin
         bad++;
         $display("FAIL rst_rel_ready: got %b want 111",
                  {awready, wready, arready});
      end
   endtask

   task automatic test_basic();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      int p0 [4];
      for (int i = 0; i < 4; i++) p0[i] = pcnt[i];
      for (int i = 0; i < 4; i++) begin
         do_write(5'(4*i), 32'(i+1), 4'hF, r, lat);
         total++;
         if (r !== 2'b00 || lat !== 0) begin
            bad++;
            $display("FAIL t1_wr[%0d]: got resp=%b lat=%0d want 00/0", i, r, lat);
         end
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (pcnt[i] - p0[i] !== 1) begin
            bad++;
            $display("FAIL t1_pulse[%0d]: got %0d want 1", i, pcnt[i] - p0[i]);
         end
      end
      total++;
      if (reg_out !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         bad++;
         $display("FAIL t1_regs: got %h want 4/3/2/1", reg_out);
      end
      for (int i = 0; i < 4; i++) begin
         do_read(5'(4*i), d, r, lat);
         total++;
         if (d !== 32'(i+1) || r !== 2'b00 || lat !== 0) begin
            bad++;
            $display("FAIL t1_rd[%0d]: got %h/%b/%0d want %h/00/0",
                     i, d, r, lat, 32'(i+1));
         end
      end
   endtask

   task automatic test_rd_wr_same_edge();
      @(negedge clk);
      awaddr = 5'h0; wdata = 32'h99; wstrb = 4'hF;
      araddr = 5'h0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      bready = 1'b1; rready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'd1) begin
         bad++;
         $display("FAIL rw_old: got v=%b d=%h want 1/00000001", rvalid, rdata);
      end
      total++;
      if (bvalid !== 1'b1) begin
         bad++;
         $display("FAIL rw_bvalid: got %b want 1", bvalid);
      end
      @(negedge clk);
      bready = 1'b0; rready = 1'b0;
      total++;
      if (reg_out[31:0] !== 32'h99 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
         bad++;
         $display("FAIL rw_after: got r0=%h b=%b r=%b want 99/0/0",
                  reg_out[31:0], bvalid, rvalid);
      end
   endtask

   task automatic test_w_first();
      @(negedge clk);
      wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      total++;
      if (wready !== 1'b0) begin
         bad++;
         $display("FAIL t2_wready: got %b want 0", wready);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
         bad++;
         $display("FAIL t2_wait: got b=%b aw=%b want 0/1", bvalid, awready);
      end
      awaddr = 5'h4; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      total++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         bad++;
         $display("FAIL t2_bvalid: got %b/%b want 1/00", bvalid, bresp);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      total++;
      if (reg_out[63:32] !== 32'hA5A5A5A5 || bvalid !== 1'b0 ||
          {awready, wready} !== 2'b11) begin
         bad++;
         $display("FAIL t2_after: got r1=%h b=%b rdy=%b want a5a5a5a5/0/11",
                  reg_out[63:32], bvalid, {awready, wready});
      end
   endtask

   task automatic test_strobe();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      do_write(5'h8, 32'hFFFFFFFF, 4'hF, r, lat);
      do_write(5'h8, 32'h12345678, 4'b0101, r, lat);
      total++;
      if (reg_out[95:64] !== 32'hFF34FF78 || r !== 2'b00) begin
         bad++;
         $display("FAIL t3_reg: got %h/%b want ff34ff78/00", reg_out[95:64], r);
      end
      do_read(5'h8, d, r, lat);
      total++;
      if (d !== 32'hFF34FF78 || r !== 2'b00) begin
         bad++;
         $display("FAIL t3_rd: got %h/%b want ff34ff78/00", d, r);
      end
      do_write(5'hC, 32'hFFFF, 4'h0, r, lat);
      total++;
      if (reg_out[127:96] !== 32'd4 || r !== 2'b00) begin
         bad++;
         $display("FAIL t3_nostrb: got %h/%b want 00000004/00", reg_out[127:96], r);
      end
   endtask

   task automatic test_out_of_range();
      logic [1:0] r;
      logic [31:0] d;
      logic [127:0] snap;
      int lat, p0, p1;
      snap = reg_out;
      p0 = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
      do_write(5'h10, 32'hDEAD, 4'hF, r, lat);
      total++;
      if (r !== 2'b10) begin
         bad++;
         $display("FAIL t4_bresp: got %b want 10", r);
      end
      @(negedge clk);
      p1 = pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3];
      total++;
      if (reg_out !== snap || p1 !== p0) begin
         bad++;
         $display("FAIL t4_side: got regs=%h pulses=%0d want %h/%0d",
                  reg_out, p1 - p0, snap, 0);
      end
      do_read(5'h14, d, r, lat);
      total++;
      if (d !== 32'h0 || r !== 2'b10) begin
         bad++;
         $display("FAIL t4_rd: got %h/%b want 0/10", d, r);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      awaddr = 5'hC; wdata = 32'h77; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (bvalid !== 1'b1 || {awready, wready} !== 2'b00) begin
            bad++;
            $display("FAIL t5_bhold[%0d]: got b=%b rdy=%b want 1/00",
                     i, bvalid, {awready, wready});
         end
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      total++;
      if (bvalid !== 1'b0 || {awready, wready} !== 2'b11 ||
          reg_out[127:96] !== 32'h77) begin
         bad++;
         $display("FAIL t5_brel: got b=%b rdy=%b r3=%h want 0/11/77",
                  bvalid, {awready, wready}, reg_out[127:96]);
      end
      araddr = 5'hC; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         total++;
         if (rvalid !== 1'b1 || rdata !== 32'h77 || arready !== 1'b0) begin
            bad++;
            $display("FAIL t5_rhold[%0d]: got v=%b d=%h ar=%b want 1/77/0",
                     i, rvalid, rdata, arready);
         end
         @(negedge clk);
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      total++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         bad++;
         $display("FAIL t5_rrel: got v=%b ar=%b want 0/1", rvalid, arready);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] r;
      logic [31:0] d;
      int lat;
      @(negedge clk);
      awaddr = 5'h0; wdata = 32'h55; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      total++;
      if (bvalid !== 1'b1 || reg_out[31:0] !== 32'h55) begin
         bad++;
         $display("FAIL t6_pre: got b=%b r0=%h want 1/55", bvalid, reg_out[31:0]);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (bvalid !== 1'b0 || reg_out !== 128'b0 ||
          {awready, wready, arready} !== 3'b000) begin
         bad++;
         $display("FAIL t6_async: got b=%b regs=%h rdy=%b want 0/0/000",
                  bvalid, reg_out, {awready, wready, arready});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({awready, wready, arready} !== 3'b111 || bvalid !== 1'b0) begin
         bad++;
         $display("FAIL t6_rel: got rdy=%b b=%b want 111/0",
                  {awready, wready, arready}, bvalid);
      end
      do_read(5'h0, d, r, lat);
      total++;
      if (d !== 32'h0 || r !== 2'b00 || lat !== 0) begin
         bad++;
         $display("FAIL t6_rd: got %h/%b/%0d want 0/00/0", d, r, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rd_wr_same_edge();
      test_w_first();
      test_strobe();
      test_out_of_range();
      test_backpressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
